// File: rtl/kgd_fill_if.sv
// Wishbone master-side signal bundle between kgd_fill and the KGD register window.
interface kgd_fill_if;
  logic [2:0]  wbm_adr_o;
  logic [15:0] wbm_dat_o;
  logic [15:0] wbm_dat_i;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [1:0]  wbm_sel_o;
  logic        wbm_ack_i;

  modport master (
    output wbm_adr_o, wbm_dat_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o,
    input  wbm_dat_i, wbm_ack_i
  );

  modport slave (
    input  wbm_adr_o, wbm_dat_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o,
    output wbm_dat_i, wbm_ack_i
  );
endinterface

// File: rtl/kgd_fill.sv
// Fills or read-verifies a run of KGD video-memory bytes through the address (4)
// and data (2) registers, one Wishbone cycle each, with an ack timeout.
module kgd_fill #(
  parameter int unsigned TMO_W = 6
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  kgd_fill_if.master  wbm,
  input  logic        cmd_start,
  input  logic        cmd_verify,
  input  logic [13:0] cmd_addr,
  input  logic [14:0] cmd_count,
  input  logic [7:0]  cmd_pattern,
  input  logic        cmd_abort,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [13:0] err_addr
);

  typedef enum logic [2:0] {IDLE, SETADR, GAP_A, XFER, GAP_D, FIN} state_t;

  // Last count value before the (2^TMO_W-1)th unacknowledged strobe cycle ends.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((1 << TMO_W) - 2);

  state_t            state, state_n;
  logic              verify_q, verify_n;
  logic [13:0]       addr_q, addr_n;
  logic [14:0]       count_q, count_n;
  logic [7:0]        pat_q, pat_n;
  logic [TMO_W-1:0]  tmo_q, tmo_n;
  logic              gap_q, gap_n;
  logic              cyc_q, cyc_n, we_q, we_n;
  logic [2:0]        adr_q, adr_n;
  logic [1:0]        sel_q, sel_n;
  logic [15:0]       dat_q, dat_n;
  logic              busy_n, done_n, err_n;
  logic [13:0]       err_addr_n;
  logic              ack_hit, tmo_hit, mismatch;
  logic              unused_dat_hi;

  assign unused_dat_hi = ^wbm.wbm_dat_i[15:8];

  assign wbm.wbm_cyc_o = cyc_q;
  assign wbm.wbm_stb_o = cyc_q;
  assign wbm.wbm_we_o  = we_q;
  assign wbm.wbm_adr_o = adr_q;
  assign wbm.wbm_sel_o = sel_q;
  assign wbm.wbm_dat_o = dat_q;

  assign ack_hit  = cyc_q & wbm.wbm_ack_i;
  assign tmo_hit  = cyc_q & ~wbm.wbm_ack_i & (tmo_q == TMO_LAST);
  assign mismatch = verify_q & (wbm.wbm_dat_i[7:0] != pat_q);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state    <= IDLE;
      verify_q <= 1'b0;
      addr_q   <= '0;
      count_q  <= '0;
      pat_q    <= '0;
      tmo_q    <= '0;
      gap_q    <= 1'b0;
      cyc_q    <= 1'b0;
      we_q     <= 1'b0;
      adr_q    <= '0;
      sel_q    <= '0;
      dat_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_addr <= '0;
    end else begin
      state    <= state_n;
      verify_q <= verify_n;
      addr_q   <= addr_n;
      count_q  <= count_n;
      pat_q    <= pat_n;
      tmo_q    <= tmo_n;
      gap_q    <= gap_n;
      cyc_q    <= cyc_n;
      we_q     <= we_n;
      adr_q    <= adr_n;
      sel_q    <= sel_n;
      dat_q    <= dat_n;
      busy     <= busy_n;
      done     <= done_n;
      err      <= err_n;
      err_addr <= err_addr_n;
    end
  end

  always_comb begin
    state_n    = state;
    verify_n   = verify_q;
    addr_n     = addr_q;
    count_n    = count_q;
    pat_n      = pat_q;
    tmo_n      = tmo_q;
    gap_n      = gap_q;
    cyc_n      = cyc_q;
    we_n       = we_q;
    adr_n      = adr_q;
    sel_n      = sel_q;
    dat_n      = dat_q;
    busy_n     = busy;
    done_n     = 1'b0;
    err_n      = err;
    err_addr_n = err_addr;

    unique case (state)
      IDLE: begin
        if (cmd_start) begin
          verify_n = cmd_verify;
          addr_n   = cmd_addr;
          count_n  = cmd_count;
          pat_n    = cmd_pattern;
          err_n    = 1'b0;
          if (cmd_count == '0) begin
            state_n = FIN;
            done_n  = 1'b1;
          end else begin
            state_n = SETADR;
            busy_n  = 1'b1;
            tmo_n   = '0;
            cyc_n   = 1'b1;
            we_n    = 1'b1;
            adr_n   = 3'b100;
            sel_n   = 2'b11;
            dat_n   = {2'b00, cmd_addr};
          end
        end
      end

      SETADR, XFER: begin
        if (ack_hit || tmo_hit) begin
          cyc_n = 1'b0;
          we_n  = 1'b0;
          adr_n = '0;
          sel_n = '0;
          dat_n = '0;
          gap_n = 1'b0;
        end
        if (tmo_hit) begin
          err_n      = 1'b1;
          err_addr_n = addr_q;
          state_n    = FIN;
        end else if (ack_hit && state == SETADR) begin
          state_n = cmd_abort ? FIN : GAP_A;
        end else if (ack_hit) begin
          addr_n  = addr_q + 14'd1;
          count_n = count_q - 15'd1;
          if (mismatch) begin
            err_n      = 1'b1;
            err_addr_n = addr_q;
            state_n    = FIN;
          end else if (count_q == 15'd1 || cmd_abort) begin
            state_n = FIN;
          end else begin
            state_n = GAP_D;
          end
        end else begin
          tmo_n = tmo_q + 1'b1;
        end
        if (state_n == FIN) begin
          busy_n = 1'b0;
          done_n = 1'b1;
        end
      end

      // Each gap lasts two idle cycles; the next strobe is launched on the edge ending the second.
      GAP_A: begin
        gap_n = 1'b1;
        if (gap_q) begin
          state_n = XFER;
          tmo_n   = '0;
          cyc_n   = 1'b1;
          we_n    = ~verify_q;
          adr_n   = 3'b010;
          sel_n   = verify_q ? 2'b11 : 2'b01;
          dat_n   = verify_q ? 16'h0000 : {8'h00, pat_q};
        end
      end

      GAP_D: begin
        gap_n = 1'b1;
        if (gap_q) begin
          state_n = SETADR;
          tmo_n   = '0;
          cyc_n   = 1'b1;
          we_n    = 1'b1;
          adr_n   = 3'b100;
          sel_n   = 2'b11;
          dat_n   = {2'b00, addr_q};
        end
      end

      FIN: state_n = IDLE;

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_kgd_fill.sv
// Scoreboarded bench for kgd_fill: KGD slave model with memory, expected bus
// cycles queued per job from a byte-level reference model, compared by a monitor.
module tb_kgd_fill;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  kgd_fill_if bus ();

  logic        cmd_start, cmd_verify, cmd_abort;
  logic [13:0] cmd_addr;
  logic [14:0] cmd_count;
  logic [7:0]  cmd_pattern;
  logic        busy, done, err;
  logic [13:0] err_addr;

  kgd_fill #(.TMO_W(6)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .wbm         (bus),
    .cmd_start   (cmd_start),
    .cmd_verify  (cmd_verify),
    .cmd_addr    (cmd_addr),
    .cmd_count   (cmd_count),
    .cmd_pattern (cmd_pattern),
    .cmd_abort   (cmd_abort),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .err_addr    (err_addr)
  );

  typedef struct packed {
    logic        we;
    logic [2:0]  adr;
    logic [1:0]  sel;
    logic [15:0] dat;
  } txn_t;

  txn_t        exp_q[$];
  logic [7:0]  mem     [16384] = '{default: 8'h00};
  logic [7:0]  ref_mem [16384] = '{default: 8'h00};
  logic [13:0] kaddr = '0;
  int unsigned hi = 0;
  logic        first = 1'b0;
  bit          never, dbl;
  logic        poke;
  logic [13:0] poke_a;
  logic [7:0]  poke_d;
  logic        bus_act;

  int unsigned pass_cnt = 0, total_cnt = 0;
  int unsigned txn_cnt = 0, done_cnt = 0, cyc_cnt = 0, run = 0, last_run = 0;

  // KGD slave: ack 3 cycles after strobe rises, optionally repeated once after strobe drops.
  assign bus_act = bus.wbm_cyc_o & bus.wbm_stb_o;
  assign bus.wbm_ack_i = !never && ((bus_act && hi == 2) || (dbl && first));
  assign bus.wbm_dat_i = {8'h00, mem[kaddr]};

  always @(posedge clk) begin
    hi    <= bus_act ? hi + 1 : 0;
    first <= bus_act && hi == 2 && !never;
    if (poke) mem[poke_a] <= poke_d;
    else if (bus_act && bus.wbm_ack_i && bus.wbm_we_o) begin
      if (bus.wbm_adr_o == 3'b100) kaddr <= bus.wbm_dat_o[13:0];
      else if (bus.wbm_adr_o == 3'b010 && bus.wbm_sel_o[0]) mem[kaddr] <= bus.wbm_dat_o[7:0];
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, required %0h", name, got, exp);
  endtask

  task automatic push(input logic we, input logic [2:0] adr, input logic [1:0] sel, input logic [15:0] dat);
    txn_t t;
    t = '{we: we, adr: adr, sel: sel, dat: dat};
    exp_q.push_back(t);
  endtask

  task automatic monitor();
    txn_t got, e;
    forever begin
      @(negedge clk);
      if (bus.wbm_cyc_o) cyc_cnt++;
      if (bus_act && bus.wbm_ack_i) begin
        txn_cnt++;
        got = '{we: bus.wbm_we_o, adr: bus.wbm_adr_o, sel: bus.wbm_sel_o, dat: bus.wbm_dat_o};
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL extra_cycle: got %0h, required none", got);
        end else begin
          e = exp_q.pop_front();
          chk("bus_cycle", 32'(got), 32'(e));
        end
      end
      if (bus.wbm_stb_o) run++;
      else begin
        if (run != 0) last_run = run;
        run = 0;
      end
      if (done) done_cnt++;
    end
  endtask

  task automatic set_mem(input logic [13:0] a, input logic [7:0] d);
    @(negedge clk);
    poke_a = a; poke_d = d; poke = 1'b1;
    @(negedge clk);
    poke = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic start(input bit v, input logic [13:0] a, input int unsigned n, input logic [7:0] p);
    @(negedge clk);
    cmd_verify = v; cmd_addr = a; cmd_count = 15'(n); cmd_pattern = p; cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
  endtask

  task automatic wait_done(input int unsigned d0);
    int unsigned c = 0;
    while (done_cnt == d0 && c < 3000) begin
      @(posedge clk);
      c++;
    end
    if (done_cnt == d0) begin
      total_cnt++;
      $display("FAIL done_timeout: got no done, required done within 3000 cycles");
    end
    repeat (3) @(negedge clk);
  endtask

  // Reference: a job is a sequence of bytes; each byte is an address write then a data
  // write (fill) or read (verify), stopping after the first failing read.
  task automatic job(input bit v, input logic [13:0] a, input int unsigned n, input logic [7:0] p);
    bit          ee = 1'b0;
    logic [13:0] ea = '0, ai;
    int unsigned np = 0, d0, t0, bad = 0;
    for (int unsigned i = 0; i < n; i++) begin
      ai = 14'(a + i);
      push(1'b1, 3'b100, 2'b11, {2'b00, ai}); np++;
      if (v) begin
        push(1'b0, 3'b010, 2'b11, 16'h0000); np++;
        if (ref_mem[ai] != p) begin ee = 1'b1; ea = ai; break; end
      end else begin
        push(1'b1, 3'b010, 2'b01, {8'h00, p}); np++;
        ref_mem[ai] = p;
      end
    end
    d0 = done_cnt; t0 = txn_cnt;
    start(v, a, n, p);
    wait_done(d0);
    chk("done_pulses", done_cnt - d0, 1);
    chk("bus_cycles", txn_cnt - t0, np);
    chk("err", 32'(err), 32'(ee));
    if (ee) chk("err_addr", 32'(err_addr), 32'(ea));
    chk("busy_after", 32'(busy), 0);
    chk("pending", exp_q.size(), 0);
    if (!v) begin
      for (int unsigned i = 0; i < n; i++) if (mem[14'(a + i)] !== ref_mem[14'(a + i)]) bad++;
      chk("mem", bad, 0);
    end
  endtask

  task automatic abort_job(input int unsigned k);
    logic [13:0] a = 14'd3000;
    int unsigned d0, t0, c = 0, bad = 0;
    for (int unsigned i = 0; i < 5; i++) begin
      push(1'b1, 3'b100, 2'b11, {2'b00, 14'(a + i)});
      push(1'b1, 3'b010, 2'b01, 16'h00C3);
    end
    for (int unsigned i = 0; i + 1 < k; i++) ref_mem[14'(a + i)] = 8'hC3;
    d0 = done_cnt; t0 = txn_cnt;
    start(1'b0, a, 5, 8'hC3);
    while (txn_cnt - t0 < k && c < 500) begin
      @(posedge clk);
      c++;
    end
    @(negedge clk);
    cmd_abort = 1'b1;
    wait_done(d0);
    cmd_abort = 1'b0;
    chk("abort_cycles", txn_cnt - t0, k + 1);
    chk("abort_err", 32'(err), 0);
    chk("abort_done", done_cnt - d0, 1);
    exp_q.delete();
    for (int unsigned i = 0; i < 5; i++) if (mem[14'(a + i)] !== ref_mem[14'(a + i)]) bad++;
    chk("abort_mem", bad, 0);
  endtask

  initial begin
    int unsigned d0, c0, n;
    logic [13:0] a;
    logic [7:0]  p;
    bit          v;

    rst = 1'b1; cmd_start = 1'b0; cmd_verify = 1'b0; cmd_abort = 1'b0;
    cmd_addr = '0; cmd_count = '0; cmd_pattern = '0;
    poke = 1'b0; poke_a = '0; poke_d = '0; never = 1'b0; dbl = 1'b0;
    fork monitor(); join_none

    repeat (3) @(negedge clk);
    chk("reset_outs", {28'h0, bus.wbm_cyc_o, busy, done, err}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_bus", {bus.wbm_we_o, bus.wbm_adr_o, bus.wbm_sel_o, bus.wbm_dat_o, err_addr}, 0);

    job(1'b0, 14'd100, 3, 8'hA5);
    job(1'b0, 14'd16383, 2, 8'h5A);
    job(1'b1, 14'd100, 3, 8'hA5);
    for (int unsigned i = 0; i < 4; i++) set_mem(14'(200 + i), 8'hFF);
    set_mem(14'd201, 8'h00);
    job(1'b1, 14'd200, 4, 8'hFF);

    dbl = 1'b1;
    job(1'b0, 14'd400, 4, 8'h77);
    job(1'b1, 14'd400, 4, 8'h77);
    dbl = 1'b0;

    never = 1'b1;
    d0 = done_cnt;
    start(1'b0, 14'd1234, 2, 8'h42);
    wait_done(d0);
    chk("tmo_stb_cycles", last_run, 63);
    chk("tmo_err", 32'(err), 1);
    chk("tmo_err_addr", 32'(err_addr), 1234);
    chk("tmo_done", done_cnt - d0, 1);

    start(1'b0, 14'd700, 3, 8'h99);
    repeat (5) @(negedge clk);
    chk("pre_rst_stb", {30'h0, bus.wbm_stb_o, busy}, 3);
    d0 = done_cnt;
    #2 rst = 1'b1;
    #1;
    chk("rst_bus", {bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_sel_o, bus.wbm_adr_o, bus.wbm_dat_o}, 0);
    chk("rst_status", {busy, done, err, err_addr}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_no_done", done_cnt - d0, 0);
    never = 1'b0;

    d0 = done_cnt; c0 = cyc_cnt;
    start(1'b0, 14'd50, 0, 8'h11);
    chk("zero_done", {30'h0, done, busy}, 2);
    wait_done(d0);
    chk("zero_done_pulses", done_cnt - d0, 1);
    chk("zero_no_cyc", cyc_cnt - c0, 0);

    abort_job(2);
    abort_job(3);

    for (int unsigned j = 0; j < 10; j++) begin
      v   = 1'($urandom_range(0, 1));
      a   = 14'($urandom_range(0, 16383));
      n   = $urandom_range(1, 6);
      p   = 8'($urandom);
      dbl = 1'($urandom_range(0, 1));
      if (v) begin
        for (int unsigned i = 0; i < n; i++) set_mem(14'(a + i), p);
        if ($urandom_range(0, 1) == 1) set_mem(14'(a + $urandom_range(0, n - 1)), p ^ 8'h5A);
      end
      job(v, a, n, p);
    end
    dbl = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
